// File: rtl/snake_nav_controller.sv
// snake_nav_controller
// Front end for the snake-head X/Y position counters. It synchronises and
// edge-detects the four buttons and keeps the current heading, refusing
// 180-degree turns. On every move-rate tick it sends one step pulse and a
// direction level to the counter of the axis being moved.
//
// state      | meaning
// -----------+--------------------------------------------
// HEAD_UP    | heading up    (Y decrements), code 00
// HEAD_RIGHT | heading right (X increments), code 01
// HEAD_DOWN  | heading down  (Y increments), code 10
// HEAD_LEFT  | heading left  (X decrements), code 11
module snake_nav_controller #(
  parameter int TICK_WIDTH = 26,
  parameter int TICK_MAX   = 24999999
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_U,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic       BTN_R,
  input  logic       PAUSE,
  output logic       X_ENABLE,
  output logic       X_DIRECTION,
  output logic       Y_ENABLE,
  output logic       Y_DIRECTION,
  output logic       MOVE_TICK,
  output logic [1:0] DIR_STATE
);

  // Opposite headings differ only in bit 1, so a reversal is "same code
  // with bit 1 flipped".
  typedef enum logic [1:0] {
    HEAD_UP    = 2'b00,
    HEAD_RIGHT = 2'b01,
    HEAD_DOWN  = 2'b10,
    HEAD_LEFT  = 2'b11
  } heading_t;

  // Button vectors are ordered {R, L, D, U}.
  logic [3:0]            r_sync1;
  logic [3:0]            r_sync2;
  logic [3:0]            r_sync3;
  logic [TICK_WIDTH-1:0] r_presc;
  heading_t              r_committed;
  heading_t              r_pending;
  logic                  r_x_enable;
  logic                  r_x_direction;
  logic                  r_y_enable;
  logic                  r_y_direction;
  logic                  r_move_tick;

  logic [3:0] w_btn_raw;
  logic [3:0] w_press;
  logic       w_req_valid;
  heading_t   w_req_dir;
  logic       w_commit;
  heading_t   w_ref;
  heading_t   w_ref_opposite;
  logic       w_accept;

  assign w_btn_raw = {BTN_R, BTN_L, BTN_D, BTN_U};
  assign w_press   = r_sync2 & ~r_sync3;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Fixed-priority pick of a single request per cycle: U > D > L > R.
  always_comb begin
    w_req_valid = 1'b0;
    w_req_dir   = HEAD_UP;
    if (w_press[0]) begin
      w_req_valid = 1'b1;
      w_req_dir   = HEAD_UP;
    end else if (w_press[1]) begin
      w_req_valid = 1'b1;
      w_req_dir   = HEAD_DOWN;
    end else if (w_press[2]) begin
      w_req_valid = 1'b1;
      w_req_dir   = HEAD_LEFT;
    end else if (w_press[3]) begin
      w_req_valid = 1'b1;
      w_req_dir   = HEAD_RIGHT;
    end
  end

  // A request is judged against the heading that will be in force after this
  // edge, so two quick turns inside one tick cannot add up to a reversal.
  assign w_commit       = !PAUSE && (r_presc == TICK_WIDTH'(TICK_MAX));
  assign w_ref          = w_commit ? r_pending : r_committed;
  assign w_ref_opposite = heading_t'(w_ref ^ 2'b10);
  assign w_accept       = w_req_valid && (w_req_dir != w_ref) &&
                          (w_req_dir != w_ref_opposite);

  // Heading FSM, move-rate prescaler and registered step outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_presc       <= '0;
      r_committed   <= HEAD_RIGHT;
      r_pending     <= HEAD_RIGHT;
      r_x_enable    <= 1'b0;
      r_y_enable    <= 1'b0;
      r_move_tick   <= 1'b0;
      r_x_direction <= 1'b1;
      r_y_direction <= 1'b1;
    end else begin
      r_x_enable  <= 1'b0;
      r_y_enable  <= 1'b0;
      r_move_tick <= 1'b0;
      if (!PAUSE) begin
        r_presc <= w_commit ? '0 : r_presc + TICK_WIDTH'(1);
      end
      if (w_accept) begin
        r_pending <= w_req_dir;
      end
      if (w_commit) begin
        r_committed <= r_pending;
        r_move_tick <= 1'b1;
        if (r_pending == HEAD_LEFT || r_pending == HEAD_RIGHT) begin
          r_x_enable    <= 1'b1;
          r_x_direction <= (r_pending == HEAD_RIGHT);
        end else begin
          r_y_enable    <= 1'b1;
          r_y_direction <= (r_pending == HEAD_DOWN);
        end
      end
    end
  end

  assign X_ENABLE    = r_x_enable;
  assign X_DIRECTION = r_x_direction;
  assign Y_ENABLE    = r_y_enable;
  assign Y_DIRECTION = r_y_direction;
  assign MOVE_TICK   = r_move_tick;
  assign DIR_STATE   = r_committed;

endmodule

// File: tb/tb_snake_nav_controller.sv
// Scoreboard bench for snake_nav_controller with a 4-cycle move period.
module tb_snake_nav_controller;

  localparam int TW = 4;
  localparam int TM = 3;
  localparam int PERIOD = TM + 1;

  localparam logic [1:0] H_UP    = 2'b00;
  localparam logic [1:0] H_RIGHT = 2'b01;
  localparam logic [1:0] H_DOWN  = 2'b10;
  localparam logic [1:0] H_LEFT  = 2'b11;

  logic       clk_sys;
  logic       reset;
  logic       btn_u, btn_d, btn_l, btn_r, pause;
  logic       x_enable, x_direction, y_enable, y_direction, move_tick;
  logic [1:0] dir_state;

  typedef struct {
    int         gap;
    logic [1:0] dir;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   gap_cnt = 0;
  logic exp_xdir = 1'b1;
  logic exp_ydir = 1'b1;

  snake_nav_controller #(.TICK_WIDTH(TW), .TICK_MAX(TM)) u_dut (
    .CLK         (clk_sys),
    .RESET       (reset),
    .BTN_U       (btn_u),
    .BTN_D       (btn_d),
    .BTN_L       (btn_l),
    .BTN_R       (btn_r),
    .PAUSE       (pause),
    .X_ENABLE    (x_enable),
    .X_DIRECTION (x_direction),
    .Y_ENABLE    (y_enable),
    .Y_DIRECTION (y_direction),
    .MOVE_TICK   (move_tick),
    .DIR_STATE   (dir_state)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pops one expected move per MOVE_TICK and checks gap, heading and levels.
  always @(negedge clk_sys) begin
    if (reset) begin
      gap_cnt  = 0;
      exp_xdir = 1'b1;
      exp_ydir = 1'b1;
    end else begin
      chk_val("tick_is_or", int'(move_tick), int'(x_enable | y_enable));
      chk_val("axis_excl", int'(x_enable & y_enable), 0);
      gap_cnt++;
      if (move_tick) begin
        if (sb.size() == 0) begin
          chk_val("unexpected_tick", int'(move_tick), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.dir == H_LEFT || e.dir == H_RIGHT) exp_xdir = (e.dir == H_RIGHT);
          else exp_ydir = (e.dir == H_DOWN);
          chk_val("tick_gap", gap_cnt, e.gap);
          chk_val("dir_state", int'(dir_state), int'(e.dir));
          chk_val("x_enable", int'(x_enable), int'(e.dir == H_LEFT || e.dir == H_RIGHT));
          chk_val("y_enable", int'(y_enable), int'(e.dir == H_UP || e.dir == H_DOWN));
          chk_val("x_direction", int'(x_direction), int'(exp_xdir));
          chk_val("y_direction", int'(y_direction), int'(exp_ydir));
        end
        gap_cnt = 0;
      end
    end
  end

  task automatic push_exp(input int gap, input logic [1:0] dir);
    exp_t e;
    e.gap = gap;
    e.dir = dir;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  // Returns just after the negedge on which the last expected move was seen.
  task automatic drain();
    bool_loop: for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk_val("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // mask is {R, L, D, U}
  task automatic press(input logic [3:0] mask, input int hold);
    {btn_r, btn_l, btn_d, btn_u} = mask;
    wait_neg(hold);
    {btn_r, btn_l, btn_d, btn_u} = 4'b0000;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_x_en"}, int'(x_enable), 0);
    chk_val({tag, "_y_en"}, int'(y_enable), 0);
    chk_val({tag, "_tick"}, int'(move_tick), 0);
    chk_val({tag, "_x_dir"}, int'(x_direction), 1);
    chk_val({tag, "_y_dir"}, int'(y_direction), 1);
    chk_val({tag, "_dir"}, int'(dir_state), int'(H_RIGHT));
  endtask

  initial begin
    reset = 1'b1;
    pause = 1'b0;
    {btn_r, btn_l, btn_d, btn_u} = 4'b0000;
    repeat (3) @(posedge clk_sys);
    wait_neg(1);
    chk_reset_outputs("rst");
    reset = 1'b0;

    // Free-running RIGHT moves, first one TICK_MAX+1 cycles after reset.
    repeat (3) push_exp(PERIOD, H_RIGHT);
    drain();

    // Held UP button: one request only.
    push_exp(PERIOD, H_UP);
    push_exp(PERIOD, H_UP);
    btn_u = 1'b1;
    wait_neg(10);
    btn_u = 1'b0;
    push_exp(PERIOD, H_UP);
    drain();

    // Back to RIGHT, then LEFT is a reversal and is ignored.
    push_exp(PERIOD, H_RIGHT);
    press(4'b1000, 2);
    drain();
    push_exp(PERIOD, H_RIGHT);
    press(4'b0100, 2);
    drain();
    push_exp(PERIOD, H_RIGHT);
    drain();

    // UP then LEFT inside one (paused, stretched) tick: LEFT rejected
    // against committed RIGHT; period stretched by 8 paused cycles.
    push_exp(PERIOD + 8, H_UP);
    pause = 1'b1;
    btn_u = 1'b1;
    wait_neg(2);
    btn_u = 1'b0;
    wait_neg(1);
    btn_l = 1'b1;
    wait_neg(2);
    btn_l = 1'b0;
    wait_neg(3);
    pause = 1'b0;
    drain();
    push_exp(PERIOD, H_UP);
    drain();
    push_exp(PERIOD, H_LEFT);
    press(4'b0100, 2);
    drain();

    // U and R together while LEFT: U wins.
    push_exp(PERIOD, H_UP);
    press(4'b1001, 2);
    drain();
    // D and R together while UP: D wins and is a reversal; R is not taken.
    push_exp(PERIOD, H_UP);
    press(4'b1010, 2);
    drain();

    // 20-cycle pause starting one cycle into the period.
    push_exp(PERIOD + 20, H_UP);
    wait_neg(1);
    pause = 1'b1;
    wait_neg(20);
    pause = 1'b0;
    drain();

    // Reset mid-period with a LEFT request in flight: request is lost.
    btn_l = 1'b1;
    wait_neg(2);
    btn_l = 1'b0;
    reset = 1'b1;
    wait_neg(1);
    chk_reset_outputs("midrst");
    wait_neg(1);
    reset = 1'b0;
    push_exp(PERIOD, H_RIGHT);
    push_exp(PERIOD, H_RIGHT);
    drain();

    wait_neg(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_nav_controller.md
Name: snake_nav_controller

Overview:
Upstream stage of the snake-head X/Y position counters (up/down wrap counters with ENABLE/DIRECTION inputs). It synchronises the four push-buttons and edge-detects them. It holds the current heading in a small state machine that rejects 180-degree reversals. On a programmable move-rate prescaler it issues one-cycle step enables plus direction levels to the X and Y counters.

Parameters:
TICK_WIDTH, 26, width of move-rate prescaler counter
TICK_MAX, 24999999, prescaler terminal count; one move every TICK_MAX+1 CLK cycles (4 Hz at 100 MHz)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
BTN_U  input  1  raw up button, asynchronous
BTN_D  input  1  raw down button, asynchronous
BTN_L  input  1  raw left button, asynchronous
BTN_R  input  1  raw right button, asynchronous
PAUSE  input  1  synchronous; 1 freezes prescaler and suppresses moves
X_ENABLE  output  1  one-cycle step pulse to X counter
X_DIRECTION  output  1  X counter direction: 1 = increment (right), 0 = decrement (left)
Y_ENABLE  output  1  one-cycle step pulse to Y counter
Y_DIRECTION  output  1  Y counter direction: 1 = increment (down), 0 = decrement (up)
MOVE_TICK  output  1  one-cycle pulse on every committed move
DIR_STATE  output  2  committed heading: UP=00, RIGHT=01, DOWN=10, LEFT=11

Behaviour:
- Clock and reset: RESET is synchronous, active-high; clock is CLK. All state is updated on posedge CLK only.
- Reset values: committed=RIGHT, pending=RIGHT, prescaler=0, synchroniser/edge regs=0, X_ENABLE=0, Y_ENABLE=0, MOVE_TICK=0, X_DIRECTION=1, Y_DIRECTION=1, DIR_STATE=01.
- Input synchroniser: each button passes through 2 flops (s1, s2) plus a history flop s3. Press event = s2 & ~s3, so a held button yields exactly one event.
- Press latency: pending updates on the 3rd rising CLK edge after a stable button rise.
- Simultaneous presses in one cycle: priority U > D > L > R; only one request per cycle.
- Reference heading: ref = pending if a commit happens this cycle, otherwise committed.
- Reversal rule: a request opposite to ref (U vs D, L vs R) is discarded. A request equal to ref is a no-op. Any other request writes pending.
- Double turn within one tick (e.g. RIGHT, then UP, then LEFT): LEFT is checked against committed RIGHT and rejected; pending stays UP.
- Prescaler, PAUSE=1: holds its value. No commit, no pulses. Button requests are still accepted into pending.
- Prescaler, PAUSE=0 and prescaler==TICK_MAX: prescaler <= 0 and a commit occurs.
- Prescaler, PAUSE=0 otherwise: prescaler increments.
- Commit (registered, same edge):
  - committed <= pending; MOVE_TICK <= 1.
  - If pending is LEFT/RIGHT: X_ENABLE <= 1 and X_DIRECTION <= (pending==RIGHT).
  - If pending is UP/DOWN: Y_ENABLE <= 1 and Y_DIRECTION <= (pending==DOWN).
  - All pulses clear the following cycle.
- Direction levels: X_DIRECTION and Y_DIRECTION change only on a commit on their own axis and otherwise hold. They are therefore stable while ENABLE is high and never glitch on the idle axis.
- Exclusivity: at most one of X_ENABLE/Y_ENABLE is high in any cycle. MOVE_TICK == X_ENABLE | Y_ENABLE always.
- DIR_STATE = committed, registered.
- Reset mid-operation: all state returns to reset values on that edge. In-flight pulses are dropped and pending requests are lost. The first move after reset is RIGHT, TICK_MAX+1 cycles after RESET deasserts.
- Prescaler arithmetic: unsigned, TICK_WIDTH bits. TICK_MAX must be < 2^TICK_WIDTH and >= 1.

Test Plan:
- TICK_MAX=3, no buttons, release RESET -> MOVE_TICK and X_ENABLE pulse every 4 cycles; X_DIRECTION=1; Y_ENABLE=0; DIR_STATE=01.
- Press BTN_U for 10 cycles mid-period -> the next commit gives Y_ENABLE=1, Y_DIRECTION=0, DIR_STATE=00; only one request is taken despite the hold.
- Heading RIGHT, press BTN_L -> rejected: X_ENABLE continues with X_DIRECTION=1 and DIR_STATE stays 01.
- Heading RIGHT, press BTN_U then BTN_L within one tick -> next commit UP, following commit LEFT (if LEFT re-pressed after the UP commit); never an immediate reversal.
- BTN_U and BTN_R rise in the same cycle while heading LEFT -> UP wins; commit DIR_STATE=00.
- PAUSE=1 for 20 cycles -> no pulses and prescaler frozen; after PAUSE=0 the next tick arrives after the remaining count. RESET mid-period -> outputs return to reset values on that edge.
